// File: rtl/multicycle_control_pkg.sv
// control_pkg: shared definitions for the multicycle controller.
//   - state_t     : FSM state encoding (FETCH, DECODE, EXEC, WB, TRAP)
//   - alu_op_t    : ALU operation code type and code constants
//   - OPC_*       : major opcode constants (OP, OP-IMM)
//   - F7_*        : funct7 values that select base/alternate operations
//   - CAUSE_*     : trap cause encodings
//   - base_alu_op : funct3 -> ALU op for the funct7=0 (base) variant
package control_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        TRAP
    } state_t;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'b0000;
    localparam alu_op_t ALU_OR   = 4'b0001;
    localparam alu_op_t ALU_ADD  = 4'b0010;
    localparam alu_op_t ALU_SLL  = 4'b0011;
    localparam alu_op_t ALU_SUB  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SLT  = 4'b0110;
    localparam alu_op_t ALU_XOR  = 4'b0111;
    localparam alu_op_t ALU_SRA  = 4'b1000;
    localparam alu_op_t ALU_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'd0;
    localparam logic [6:0] F7_ALT  = 7'd32;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/instruction-memory bundle.
//   Inputs to the controller : imem_ack, instr[31:0], trap_clr
//   Outputs of the controller: imem_req, ir_we, alu_op[3:0], alu_src_imm,
//                              ru_wr, pc_we, trap, trap_cause, instret[31:0]
//   modport master : the controller side
//   modport slave  : the environment (memory / datapath / testbench) side
interface multicycle_control_if;
    import control_pkg::*;

    logic        imem_ack;
    logic [31:0] instr;
    logic        trap_clr;
    logic        imem_req;
    logic        ir_we;
    alu_op_t     alu_op;
    logic        alu_src_imm;
    logic        ru_wr;
    logic        pc_we;
    logic        trap;
    logic        trap_cause;
    logic [31:0] instret;

    modport master (
        input  imem_ack, instr, trap_clr,
        output imem_req, ir_we, alu_op, alu_src_imm, ru_wr, pc_we,
               trap, trap_cause, instret
    );

    modport slave (
        output imem_ack, instr, trap_clr,
        input  imem_req, ir_we, alu_op, alu_src_imm, ru_wr, pc_we,
               trap, trap_cause, instret
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: combinational opcode/funct3/funct7 -> {alu_op, legal, alu_src_imm}.
//   opcode_i[6:0], funct3_i[2:0], funct7_i[6:0] : instruction fields
//   alu_op_o[3:0]  : ALU operation (meaningful only when legal_o=1)
//   legal_o        : instruction is supported
//   alu_src_imm_o  : operand B is the immediate
// Optional feature macro: MULTICYCLE_OPIMM_EN (enables OP-IMM decode).
// Without it OP-IMM is illegal and alu_src_imm_o is constant 0.
module alu_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_t    alu_op_o,
    output logic       legal_o,
    output logic       alu_src_imm_o
);

    logic f7_base;
    logic f7_alt;
    logic has_alt;

    assign f7_base = (funct7_i == F7_BASE);
    assign f7_alt  = (funct7_i == F7_ALT);
    // Only ADD/SUB (funct3 0) and SRL/SRA (funct3 5) have an alternate form.
    assign has_alt = (funct3_i == 3'd0) || (funct3_i == 3'd5);

    always_comb begin
        alu_op_o      = ALU_AND;
        legal_o       = 1'b0;
        alu_src_imm_o = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                legal_o  = f7_base || (f7_alt && has_alt);
                alu_op_o = base_alu_op(funct3_i);
                if (f7_alt) begin
                    alu_op_o = (funct3_i == 3'd0) ? ALU_SUB : ALU_SRA;
                end
            end
`ifdef MULTICYCLE_OPIMM_EN
            OPC_OP_IMM: begin
                // The immediate occupies funct7 for most funct3 values, so
                // funct7 only matters for the shifts.
                alu_src_imm_o = 1'b1;
                alu_op_o      = base_alu_op(funct3_i);
                case (funct3_i)
                    3'd1:    legal_o = f7_base;
                    3'd5: begin
                        legal_o = f7_base || f7_alt;
                        if (f7_alt) begin
                            alu_op_o = ALU_SRA;
                        end
                    end
                    default: legal_o = 1'b1;
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/WB controller with a TRAP state.
//   clk, rst  : clock and synchronous active-high reset
//   cif       : multicycle_control_if.master (imem handshake, strobes,
//               ALU controls, trap status, retired-instruction counter)
// Parameter IMEM_TIMEOUT: FETCH cycles allowed without imem_ack before a
// timeout trap. Optional feature macro: MULTICYCLE_OPIMM_EN (in alu_decoder).
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned IMEM_TIMEOUT = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master cif
);

    localparam int unsigned      WAIT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       ir_q, ir_d;
    alu_op_t           alu_op_q, alu_op_d;
    logic              src_imm_q, src_imm_d;
    logic              cause_q, cause_d;
    logic [31:0]       instret_q, instret_d;

    alu_op_t dec_op;
    logic    dec_legal;
    logic    dec_imm;
    logic    unused_ir_bits;

    alu_decoder u_dec (
        .opcode_i      (ir_q[6:0]),
        .funct3_i      (ir_q[14:12]),
        .funct7_i      (ir_q[31:25]),
        .alu_op_o      (dec_op),
        .legal_o       (dec_legal),
        .alu_src_imm_o (dec_imm)
    );

    // Register/immediate fields are datapath business, not the controller's.
    assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            ir_q      <= '0;
            alu_op_q  <= ALU_AND;
            src_imm_q <= 1'b0;
            cause_q   <= CAUSE_ILLEGAL;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            src_imm_q <= src_imm_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        src_imm_d = src_imm_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                // Ack is tested first so it wins in the last allowed cycle.
                if (cif.imem_ack) begin
                    ir_d    = cif.instr;
                    wait_d  = '0;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                alu_op_d  = dec_op;
                src_imm_d = dec_imm;
                if (dec_legal) begin
                    state_d = EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = TRAP;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end
            TRAP: begin
                if (cif.trap_clr) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        cif.imem_req    = (state_q == FETCH);
        cif.ir_we       = (state_q == FETCH) && cif.imem_ack;
        cif.ru_wr       = (state_q == WB);
        // Leaving an illegal-instruction trap skips the offending PC; a
        // timeout trap leaves the PC alone so the fetch is retried.
        cif.pc_we       = (state_q == WB) ||
                          ((state_q == TRAP) && cif.trap_clr && (cause_q == CAUSE_ILLEGAL));
        cif.trap        = (state_q == TRAP);
        cif.alu_op      = alu_op_q;
        cif.alu_src_imm = src_imm_q;
        cif.trap_cause  = cause_q;
        cif.instret     = instret_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// Stimulus pushes the reference model's expected event (retire or trap)
// into a queue; a negedge monitor pops and compares whenever the DUT
// retires (ru_wr) or enters TRAP. Honors MULTICYCLE_OPIMM_EN.
module tb_multicycle_control;
    import control_pkg::*;

    localparam int unsigned TMO = 16;
`ifdef MULTICYCLE_OPIMM_EN
    localparam bit OPIMM = 1'b1;
`else
    localparam bit OPIMM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.IMEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .cif (bus)
    );

    typedef struct {
        bit          is_trap;
        bit          cause;
        logic [3:0]  op;
        bit          imm;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_instret = '0;
    bit          m_cause = 1'b0;
    logic        trap_prev = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference decode from the ISA mnemonic table.
    function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                       output logic [3:0] op, output bit imm);
        int unsigned tf3[10] = '{0, 0, 7, 6, 1, 5, 5, 2, 3, 4};
        int unsigned tf7[10] = '{0, 32, 0, 0, 0, 0, 32, 0, 0, 0};
        logic [3:0]  top[10] = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0011,
                                 4'b0101, 4'b1000, 4'b0110, 4'b1001, 4'b0111};
        int unsigned f3 = w[14:12];
        int unsigned f7 = w[31:25];
        int unsigned key7;
        bit          known = 1'b0;
        legal = 1'b0;
        op    = 4'b0000;
        imm   = 1'b0;
        key7  = f7;
        if (w[6:0] == 7'b0110011) begin
            known = 1'b1;
        end else if (w[6:0] == 7'b0010011 && OPIMM) begin
            // Immediate instructions: funct7 is part of the immediate
            // except for the shifts.
            known = 1'b1;
            imm   = 1'b1;
            if (f3 != 1 && f3 != 5) key7 = 0;
        end
        if (known) begin
            for (int i = 0; i < 10; i++) begin
                if (tf3[i] == f3 && tf7[i] == key7) begin
                    legal = 1'b1;
                    op    = top[i];
                end
            end
        end
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        logic [4:0] rs2 = 5'($urandom);
        logic [4:0] rs1 = 5'($urandom);
        logic [4:0] rd  = 5'($urandom);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    task automatic push_expect(input logic [31:0] w);
        exp_t       e;
        bit         lg;
        logic [3:0] op;
        bit         im;
        ref_decode(w, lg, op, im);
        e.is_trap = !lg;
        e.cause   = 1'b0;
        e.op      = op;
        e.imm     = im;
        e.instret = m_instret;
        sb.push_back(e);
        if (lg) m_instret = m_instret + 32'd1;
        m_cause = 1'b0;
    endtask

    // Called at a negedge with the DUT in FETCH. Returns at the negedge
    // after the ack (DUT in DECODE). trap_clr is toggled randomly while
    // outside TRAP, where it must have no effect.
    task automatic fetch(input logic [31:0] w, input int unsigned delay, input bit expect_it);
        for (int unsigned i = 0; i < delay; i++) begin
            bus.imem_ack = 1'b0;
            bus.trap_clr = 1'($urandom_range(0, 1));
            #1;
            check("fetch_wait_req", {bus.imem_req, bus.ir_we, bus.pc_we}, 3'b100);
            @(negedge clk);
        end
        if (expect_it) push_expect(w);
        bus.imem_ack = 1'b1;
        bus.instr    = w;
        bus.trap_clr = 1'($urandom_range(0, 1));
        #1;
        check("ir_we_on_ack", {bus.imem_req, bus.ir_we}, 2'b11);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.trap_clr = 1'b0;
        bus.instr    = $urandom;
    endtask

    task automatic clear_trap();
        check("trap_strobes_low", {bus.trap, bus.imem_req, bus.ir_we, bus.ru_wr, bus.pc_we}, 5'b10000);
        bus.trap_clr = 1'b1;
        #1;
        check("trap_clr_pc_we", bus.pc_we, !m_cause);
        @(negedge clk);
        bus.trap_clr = 1'b0;
        check("after_clr_fetch", {bus.trap, bus.imem_req}, 2'b01);
        check("after_clr_instret", bus.instret, m_instret);
    endtask

    // Wait (bounded) until the instruction retires back to FETCH or traps.
    task automatic settle();
        int unsigned n = 0;
        while (!bus.imem_req && !bus.trap && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            n_cmp++;
            n_err++;
            $display("FAIL settle_bound: got no FETCH/TRAP within 10 cycles at %0t", $time);
        end
        if (bus.trap) clear_trap();
    endtask

    task automatic timeout_run();
        exp_t        e;
        int unsigned cnt = 0;
        int unsigned n   = 0;
        e.is_trap = 1'b1;
        e.cause   = 1'b1;
        e.op      = 4'b0000;
        e.imm     = 1'b0;
        e.instret = m_instret;
        sb.push_back(e);
        m_cause      = 1'b1;
        bus.imem_ack = 1'b0;
        while (!bus.trap && n < 40) begin
            if (bus.imem_req) cnt++;
            @(negedge clk);
            n++;
        end
        check("timeout_fetch_cycles", cnt, TMO);
        if (bus.trap) clear_trap();
    endtask

    // Monitor: pops one expectation per observed retire / trap entry.
    always @(negedge clk) begin
        if (rst) begin
            trap_prev <= 1'b0;
        end else begin
            trap_prev <= bus.trap;
            if (bus.ru_wr || (bus.trap && !trap_prev)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got ru_wr=%0b trap=%0b expected none at %0t",
                             bus.ru_wr, bus.trap, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind", {bus.ru_wr, bus.trap}, mon_e.is_trap ? 2'b01 : 2'b10);
                    if (mon_e.is_trap) begin
                        check("trap_cause", bus.trap_cause, mon_e.cause);
                    end else begin
                        check("retire_alu_op", bus.alu_op, mon_e.op);
                        check("retire_src_imm", bus.alu_src_imm, mon_e.imm);
                        check("retire_pc_we", bus.pc_we, 1);
                    end
                    check("event_instret", bus.instret, mon_e.instret);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int unsigned k;

        rst          = 1'b1;
        bus.imem_ack = 1'b0;
        bus.instr    = '0;
        bus.trap_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.trap, bus.ru_wr, bus.pc_we, bus.alu_op, bus.alu_src_imm, bus.trap_cause},
              9'b0);
        check("rst_instret", bus.instret, 0);
        rst = 1'b0;
        check("req_after_release", bus.imem_req, 1);

        // add with ack in the first FETCH cycle: 4-cycle instruction
        fetch(32'h00208033, 0, 1'b1);
        check("decode_no_wr", bus.ru_wr, 0);
        @(negedge clk);
        check("exec_alu_op_add", bus.alu_op, 4'b0010);
        @(negedge clk);
        check("wb_strobes", {bus.ru_wr, bus.pc_we}, 2'b11);
        @(negedge clk);
        check("instret_one", bus.instret, 1);
        check("back_to_fetch", bus.imem_req, 1);

        fetch(mk(7'd32, 3'd5, 7'b0110011), 0, 1'b1);   // sra
        settle();
        fetch(mk(7'd1, 3'd0, 7'b0110011), 0, 1'b1);    // illegal funct7
        settle();
        timeout_run();
        fetch(32'h00208033, TMO - 1, 1'b1);            // ack in the last allowed cycle
        settle();
        fetch(32'h00500093, 0, 1'b1);                  // addi
        settle();

        // Reset while in EXEC: no retire, counter cleared.
        fetch(32'h40208033, 0, 1'b0);
        @(negedge clk);
        check("exec_alu_op_sub", bus.alu_op, 4'b0100);
        rst = 1'b1;
        @(negedge clk);
        check("rst_exec_state", {bus.imem_req, bus.ru_wr, bus.pc_we, bus.trap}, 4'b1000);
        check("rst_exec_instret", bus.instret, 0);
        check("rst_exec_alu_op", bus.alu_op, 0);
        rst       = 1'b0;
        m_instret = '0;

        // Counter wrap: preset to all-ones, retire two.
        dut.instret_q = 32'hFFFF_FFFF;
        m_instret     = 32'hFFFF_FFFF;
        fetch(mk(7'd0, 3'd7, 7'b0110011), 0, 1'b1);
        settle();
        fetch(mk(7'd0, 3'd4, 7'b0110011), 2, 1'b1);
        settle();
        check("instret_wrap", bus.instret, 32'h0000_0001);

        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: w = mk(($urandom_range(0, 3) == 0) ? 7'd32 : 7'd0, 3'($urandom), 7'b0110011);
                4, 5:       w = mk(($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'd32, 3'($urandom), 7'b0010011);
                6:          w = mk(7'($urandom), 3'($urandom), 7'b0110011);
                default:    w = $urandom;
            endcase
            if (k == 9 && $urandom_range(0, 1) == 0) begin
                timeout_run();
            end else begin
                fetch(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : 0, 1'b1);
                settle();
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_instret", bus.instret, m_instret);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter IMEM_TIMEOUT, default 16: the maximum number of FETCH cycles spent waiting for imem_ack before a timeout trap.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_ack  input  1  instruction memory has instr valid this cycle.
REQ-005 The block SHALL have port instr  input  32  instruction word, sampled when imem_ack=1 in FETCH.
REQ-006 The block SHALL have port trap_clr  input  1  leave TRAP; ignored in all other states.
REQ-007 The block SHALL have port imem_req  output  1  fetch request.
REQ-008 The block SHALL have port ir_we  output  1  instruction register load strobe.
REQ-009 The block SHALL have port alu_op  output  4  ALU operation code.
REQ-010 The block SHALL have port alu_src_imm  output  1  ALU operand B is the immediate.
REQ-011 The block SHALL have port ru_wr  output  1  register unit write enable.
REQ-012 The block SHALL have port pc_we  output  1  PC advance strobe.
REQ-013 The block SHALL have port trap  output  1  controller halted in TRAP.
REQ-014 The block SHALL have port trap_cause  output  1  trap reason: 0 = illegal instruction, 1 = fetch timeout.
REQ-015 The block SHALL have port instret  output  32  retired-instruction counter.

Function
REQ-016 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, WB, TRAP.
REQ-017 In FETCH, imem_req SHALL be 1, and when imem_ack=1 the block SHALL assert ir_we the same cycle, capture instr, and go to DECODE.
REQ-018 A wait counter SHALL count FETCH cycles without ack, and if it reaches IMEM_TIMEOUT-1 with imem_ack=0 the FSM SHALL go to TRAP with trap_cause=1.
REQ-019 If imem_ack arrives in the final allowed FETCH cycle, the ack SHALL win and no timeout SHALL occur.
REQ-020 DECODE SHALL last one cycle, register alu_op and alu_src_imm, and go to EXEC if the instruction is legal, else to TRAP with trap_cause=0.
REQ-021 Opcode 0110011 decode SHALL be (funct3/funct7 -> alu_op): 0/0 add 0010; 0/32 sub 0100; 7/0 and 0000; 6/0 or 0001; 1/0 sll 0011; 5/0 srl 0101; 5/32 sra 1000; 2/0 slt 0110; 3/0 sltu 1001; 4/0 xor 0111.
REQ-022 Any other funct7 value, or any other opcode, SHALL be illegal.
REQ-023 EXEC SHALL last one cycle, holding alu_op and alu_src_imm stable.
REQ-024 WB SHALL last one cycle and pulse ru_wr=1 and pc_we=1, increment instret (wrapping 0xFFFFFFFF -> 0), and return to FETCH.
REQ-025 Minimum instruction latency SHALL be 4 cycles (ack in the first FETCH cycle).
REQ-026 The block SHALL never assert ru_wr outside WB and SHALL never assert it for an illegal instruction.
REQ-027 In TRAP, trap SHALL be 1 and all strobes (imem_req, ir_we, ru_wr, pc_we) SHALL be 0.
REQ-028 On trap_clr in TRAP, the FSM SHALL go to FETCH next cycle, pulsing pc_we that cycle only if trap_cause=0 (skip the illegal instruction; a timeout retries the same PC).
REQ-029 instret SHALL NOT increment on a trap or on trap_clr.

Reset
REQ-030 When rst=1 on a clock edge, the block SHALL force state=FETCH, wait counter=0, instret=0, alu_op=0000, alu_src_imm=0, trap_cause=0, and ir_we/ru_wr/pc_we/trap=0, regardless of the current state, including mid-instruction.
REQ-031 imem_req SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 The macro MULTICYCLE_OPIMM_EN SHALL, when defined, make opcode 0010011 legal with alu_src_imm=1.
REQ-033 With MULTICYCLE_OPIMM_EN defined, OP-IMM decode SHALL be: funct3 0 always add; funct3 1 requires funct7=0; funct3 5 decodes funct7 0 as srl and 32 as sra; other funct3 values ignore funct7.
REQ-034 Without MULTICYCLE_OPIMM_EN, opcode 0010011 SHALL be illegal and alu_src_imm SHALL be tied to 0.

Structure
REQ-035 A shared package control_pkg SHALL hold the FSM state enum, the alu_op code constants, and the opcode constants.
REQ-036 The combinational funct3/funct7/opcode -> {alu_op, legal, alu_src_imm} mapping SHALL be a single sub-module named alu_decoder.

Verification
REQ-037 Reset, then instr=0x00208033 (add) with ack in the first FETCH cycle -> ir_we at cycle 1, alu_op=0010 in EXEC, ru_wr and pc_we pulse at cycle 4, instret=1.
REQ-038 instr funct3=5, funct7=32 -> alu_op=1000; funct3=0, funct7=1 -> TRAP, trap_cause=0, no ru_wr, instret unchanged; trap_clr -> one pc_we pulse, then FETCH.
REQ-039 imem_ack held low with IMEM_TIMEOUT=16 -> TRAP after 16 FETCH cycles, trap_cause=1; ack on the 16th cycle instead -> DECODE, no trap.
REQ-040 rst asserted during EXEC -> next cycle state=FETCH, no ru_wr, instret=0.
REQ-041 instret preset near wrap (retire 2 instructions from 0xFFFFFFFF) -> instret=0x00000001.
REQ-042 instr=0x00500093 (addi) -> with MULTICYCLE_OPIMM_EN: alu_src_imm=1, alu_op=0010, retires; without: TRAP, trap_cause=0.
